// File: rtl/oled_i2c_sequencer.sv
// oled_i2c_sequencer: sequences a single-byte I2C master for an SSD1306 OLED.
// Power-up delay, fixed 25-byte command init ROM, optional display RAM clear,
// then forwards user command/data bytes from a valid/ready port.
// Optional feature macro: OLED_CLEAR_EN (clear display RAM after init).
module oled_i2c_sequencer #(
   parameter int unsigned PWRUP_CYC   = 5000000,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter int unsigned CLEAR_BYTES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       usr_valid,
   input  logic [7:0] usr_data,
   input  logic       usr_is_cmd,
   output logic       usr_ready,
   output logic       i2c_start,
   output logic [7:0] i2c_data,
   output logic       i2c_is_cmd,
   input  logic       i2c_busy,
   output logic       init_done,
   output logic       err
);

   localparam int unsigned ROM_LEN = 25;
   localparam int unsigned IDX_W   = 5;
   localparam int unsigned CNT_W   = 32;
   localparam logic [IDX_W-1:0] ROM_LAST = IDX_W'(ROM_LEN - 1);
   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWRUP_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
`ifdef OLED_CLEAR_EN
   localparam int unsigned CLR_W = (CLEAR_BYTES > 1) ? $clog2(CLEAR_BYTES) : 1;
   localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_BYTES - 1);
`endif

   // Zero timeout or zero clear length would make the terminal compares wrap.
   if (TIMEOUT_CYC == 0 || CLEAR_BYTES == 0) begin : g_cfg_check
      $error("oled_i2c_sequencer: TIMEOUT_CYC and CLEAR_BYTES must be nonzero");
   end

   typedef enum logic [3:0] {
      PWRUP,
      INIT_ISSUE,
      INIT_WAIT,
`ifdef OLED_CLEAR_EN
      CLEAR_ISSUE,
      CLEAR_WAIT,
`endif
      READY,
      USR_ISSUE,
      USR_WAIT,
      ERROR
   } state_e;

   // SSD1306 128x64 init sequence; bytes 10/11 select horizontal addressing.
   function automatic logic [7:0] rom_byte(input logic [IDX_W-1:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         5'd0:    b = 8'hAE;
         5'd1:    b = 8'hD5;
         5'd2:    b = 8'h80;
         5'd3:    b = 8'hA8;
         5'd4:    b = 8'h3F;
         5'd5:    b = 8'hD3;
         5'd6:    b = 8'h00;
         5'd7:    b = 8'h40;
         5'd8:    b = 8'h8D;
         5'd9:    b = 8'h14;
         5'd10:   b = 8'h20;
         5'd11:   b = 8'h00;
         5'd12:   b = 8'hA1;
         5'd13:   b = 8'hC8;
         5'd14:   b = 8'hDA;
         5'd15:   b = 8'h12;
         5'd16:   b = 8'h81;
         5'd17:   b = 8'hCF;
         5'd18:   b = 8'hD9;
         5'd19:   b = 8'hF1;
         5'd20:   b = 8'hDB;
         5'd21:   b = 8'h40;
         5'd22:   b = 8'hA4;
         5'd23:   b = 8'hA6;
         5'd24:   b = 8'hAF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] pwr_cnt_q, pwr_cnt_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic [IDX_W-1:0] rom_idx_q, rom_idx_d;
`ifdef OLED_CLEAR_EN
   logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif
   logic             ready_q, ready_d;
   logic             start_q, start_d;
   logic [7:0]       data_q, data_d;
   logic             is_cmd_q, is_cmd_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             phase_c;
   logic             timeout_c;

   assign phase_c   = (state_q == INIT_ISSUE) || (state_q == INIT_WAIT) ||
`ifdef OLED_CLEAR_EN
                      (state_q == CLEAR_ISSUE) || (state_q == CLEAR_WAIT) ||
`endif
                      (state_q == USR_ISSUE) || (state_q == USR_WAIT);
   assign timeout_c = (to_cnt_q == TMO_LAST);

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= PWRUP;
         pwr_cnt_q <= '0;
         to_cnt_q  <= '0;
         rom_idx_q <= '0;
`ifdef OLED_CLEAR_EN
         clr_cnt_q <= '0;
`endif
         ready_q   <= 1'b0;
         start_q   <= 1'b0;
         data_q    <= 8'h00;
         is_cmd_q  <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pwr_cnt_q <= pwr_cnt_d;
         to_cnt_q  <= to_cnt_d;
         rom_idx_q <= rom_idx_d;
`ifdef OLED_CLEAR_EN
         clr_cnt_q <= clr_cnt_d;
`endif
         ready_q   <= ready_d;
         start_q   <= start_d;
         data_q    <= data_d;
         is_cmd_q  <= is_cmd_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Next-state and next-output logic; outputs are computed one edge ahead.
   always_comb begin
      state_d   = state_q;
      pwr_cnt_d = pwr_cnt_q;
      to_cnt_d  = '0;
      rom_idx_d = rom_idx_q;
`ifdef OLED_CLEAR_EN
      clr_cnt_d = clr_cnt_q;
`endif
      ready_d   = ready_q;
      start_d   = start_q;
      data_d    = data_q;
      is_cmd_d  = is_cmd_q;
      done_d    = done_q;
      err_d     = err_q;

      case (state_q)
         PWRUP: begin
            if (PWRUP_CYC == 0 || pwr_cnt_q == PWR_LAST) begin
               state_d   = INIT_ISSUE;
               rom_idx_d = '0;
               start_d   = 1'b1;
               data_d    = rom_byte('0);
               is_cmd_d  = 1'b1;
            end else begin
               pwr_cnt_d = pwr_cnt_q + CNT_W'(1);
            end
         end
         INIT_ISSUE: begin
            if (i2c_busy) begin
               start_d = 1'b0;
               state_d = INIT_WAIT;
            end else if (timeout_c) begin
               state_d = ERROR;
            end
         end
         INIT_WAIT: begin
            if (!i2c_busy) begin
               if (rom_idx_q == ROM_LAST) begin
`ifdef OLED_CLEAR_EN
                  state_d   = CLEAR_ISSUE;
                  clr_cnt_d = '0;
                  start_d   = 1'b1;
                  data_d    = 8'h00;
                  is_cmd_d  = 1'b0;
`else
                  state_d   = READY;
                  ready_d   = 1'b1;
                  done_d    = 1'b1;
`endif
               end else begin
                  rom_idx_d = rom_idx_q + IDX_W'(1);
                  state_d   = INIT_ISSUE;
                  start_d   = 1'b1;
                  data_d    = rom_byte(rom_idx_q + IDX_W'(1));
                  is_cmd_d  = 1'b1;
               end
            end else if (timeout_c) begin
               state_d = ERROR;
            end
         end
`ifdef OLED_CLEAR_EN
         CLEAR_ISSUE: begin
            if (i2c_busy) begin
               start_d = 1'b0;
               state_d = CLEAR_WAIT;
            end else if (timeout_c) begin
               state_d = ERROR;
            end
         end
         CLEAR_WAIT: begin
            if (!i2c_busy) begin
               if (clr_cnt_q == CLR_LAST) begin
                  state_d = READY;
                  ready_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  clr_cnt_d = clr_cnt_q + CLR_W'(1);
                  state_d   = CLEAR_ISSUE;
                  start_d   = 1'b1;
               end
            end else if (timeout_c) begin
               state_d = ERROR;
            end
         end
`endif
         READY: begin
            if (usr_valid) begin
               data_d   = usr_data;
               is_cmd_d = usr_is_cmd;
               start_d  = 1'b1;
               ready_d  = 1'b0;
               state_d  = USR_ISSUE;
            end
         end
         USR_ISSUE: begin
            if (i2c_busy) begin
               start_d = 1'b0;
               state_d = USR_WAIT;
            end else if (timeout_c) begin
               state_d = ERROR;
            end
         end
         USR_WAIT: begin
            if (!i2c_busy) begin
               state_d = READY;
               ready_d = 1'b1;
            end else if (timeout_c) begin
               state_d = ERROR;
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = ERROR;
         end
      endcase

      // Any timeout lands here; error outputs override the per-state values.
      if (state_d == ERROR) begin
         start_d = 1'b0;
         ready_d = 1'b0;
         err_d   = 1'b1;
      end

      // Phase timer restarts on every state change.
      if (phase_c && state_d == state_q) begin
         to_cnt_d = to_cnt_q + CNT_W'(1);
      end
   end

   assign usr_ready  = ready_q;
   assign i2c_start  = start_q;
   assign i2c_data   = data_q;
   assign i2c_is_cmd = is_cmd_q;
   assign init_done  = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_oled_i2c_sequencer.sv
// Directed bench for oled_i2c_sequencer with a simple busy-responding master model.
module tb_oled_i2c_sequencer;

   localparam int unsigned PWR = 10;
   localparam int unsigned TMO = 50;
   localparam int unsigned CLR = 4;
`ifdef OLED_CLEAR_EN
   localparam int NCLR = 4;
`else
   localparam int NCLR = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       usr_valid = 1'b0;
   logic [7:0] usr_data = 8'h00;
   logic       usr_is_cmd = 1'b0;
   logic       usr_ready;
   logic       i2c_start;
   logic [7:0] i2c_data;
   logic       i2c_is_cmd;
   logic       i2c_busy = 1'b0;
   logic       init_done;
   logic       err;

   logic       busy_en = 1'b1;
   int         bcnt = 0;
   int         cyc = 0;
   int         viol = 0;
   logic       start_prev = 1'b0;
   int         checks = 0;
   int         errors = 0;

   logic [7:0] log_data[$];
   logic       log_cmd[$];
   int         log_cyc[$];

   logic [7:0] rom [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                            8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                            8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                            8'hAF};

   oled_i2c_sequencer #(
      .PWRUP_CYC  (PWR),
      .TIMEOUT_CYC(TMO),
      .CLEAR_BYTES(CLR)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .usr_valid (usr_valid),
      .usr_data  (usr_data),
      .usr_is_cmd(usr_is_cmd),
      .usr_ready (usr_ready),
      .i2c_start (i2c_start),
      .i2c_data  (i2c_data),
      .i2c_is_cmd(i2c_is_cmd),
      .i2c_busy  (i2c_busy),
      .init_done (init_done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Master model: busy rises 3 cycles after start is seen and stays high 20 cycles.
   always @(posedge clk) begin
      if (rst || !busy_en) begin
         bcnt     <= 0;
         i2c_busy <= 1'b0;
      end else if (bcnt == 0) begin
         if (i2c_start && !i2c_busy) bcnt <= 1;
      end else begin
         bcnt <= bcnt + 1;
         if (bcnt == 2) i2c_busy <= 1'b1;
         if (bcnt == 22) begin
            i2c_busy <= 1'b0;
            bcnt     <= 0;
         end
      end
   end

   // Transaction logger: one entry per rising edge of i2c_start.
   always @(negedge clk) begin
      if (i2c_start && !start_prev) begin
         log_data.push_back(i2c_data);
         log_cmd.push_back(i2c_is_cmd);
         log_cyc.push_back(cyc);
         if (i2c_busy) viol = viol + 1;
      end
      start_prev = i2c_start;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_log();
      log_data.delete();
      log_cmd.delete();
      log_cyc.delete();
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (log_data.size() < n && k < budget) begin
         step();
         k++;
      end
      checks++;
      if (log_data.size() < n) begin
         errors++;
         $display("FAIL %s: got %0d transactions, expected at least %0d", name, log_data.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      usr_valid = 1'b0;
      repeat (3) step();
      checks++; if (usr_ready !== 1'b0) begin errors++; $display("FAIL reset_usr_ready: got %b expected 0", usr_ready); end
      checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL reset_i2c_start: got %b expected 0", i2c_start); end
      checks++; if (i2c_data !== 8'h00) begin errors++; $display("FAIL reset_i2c_data: got %h expected 00", i2c_data); end
      checks++; if (i2c_is_cmd !== 1'b1) begin errors++; $display("FAIL reset_i2c_is_cmd: got %b expected 1", i2c_is_cmd); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
   endtask

   task automatic test_init();
      int c0, n, done_cyc, last;
      clear_log();
      c0 = cyc;
      rst = 1'b0;
      n = 0;
      while (init_done !== 1'b1 && n < 3000) begin
         step();
         n++;
      end
      done_cyc = cyc;
      checks++;
      if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_timeout: got %b expected 1", init_done); end
      checks++;
      if (log_data.size() != 25 + NCLR) begin
         errors++; $display("FAIL init_count: got %0d expected %0d", log_data.size(), 25 + NCLR);
      end
      if (log_data.size() > 0) begin
         checks++;
         if (log_cyc[0] - c0 != 10) begin errors++; $display("FAIL init_first_latency: got %0d expected 10", log_cyc[0] - c0); end
      end
      for (int i = 0; i < 25 + NCLR; i++) begin
         if (i < log_data.size()) begin
            checks++;
            if (i < 25) begin
               if (log_data[i] !== rom[i] || log_cmd[i] !== 1'b1) begin
                  errors++; $display("FAIL init_rom_%0d: got %h/%b expected %h/1", i, log_data[i], log_cmd[i], rom[i]);
               end
            end else begin
               if (log_data[i] !== 8'h00 || log_cmd[i] !== 1'b0) begin
                  errors++; $display("FAIL clear_byte_%0d: got %h/%b expected 00/0", i - 25, log_data[i], log_cmd[i]);
               end
            end
         end
      end
      last = log_cyc.size() - 1;
      if (last >= 0) begin
         checks++;
         if (done_cyc - log_cyc[last] != 24) begin
            errors++; $display("FAIL init_done_timing: got %0d expected 24", done_cyc - log_cyc[last]);
         end
      end
      checks++; if (usr_ready !== 1'b1) begin errors++; $display("FAIL init_usr_ready: got %b expected 1", usr_ready); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL init_err: got %b expected 0", err); end
   endtask

   task automatic test_user_byte(input logic [7:0] d, input logic c);
      int base, n;
      base = log_data.size();
      usr_data = d;
      usr_is_cmd = c;
      usr_valid = 1'b1;
      step();
      usr_valid = 1'b0;
      usr_data = 8'hFF;
      checks++; if (i2c_start !== 1'b1) begin errors++; $display("FAIL usr_start_latency: got %b expected 1", i2c_start); end
      checks++; if (i2c_data !== d) begin errors++; $display("FAIL usr_data_latched: got %h expected %h", i2c_data, d); end
      n = 0;
      while (usr_ready !== 1'b1 && n < 200) begin
         n++;
         step();
      end
      checks++; if (n != 24) begin errors++; $display("FAIL usr_ready_low_cycles: got %0d expected 24", n); end
      checks++;
      if (log_data.size() != base + 1) begin
         errors++; $display("FAIL usr_txn_count: got %0d expected %0d", log_data.size() - base, 1);
      end else if (log_data[base] !== d || log_cmd[base] !== c) begin
         errors++; $display("FAIL usr_txn_byte: got %h/%b expected %h/%b", log_data[base], log_cmd[base], d, c);
      end
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL usr_init_done: got %b expected 1", init_done); end
   endtask

   task automatic test_back_to_back();
      int base, n;
      base = log_data.size();
      usr_data = 8'h81;
      usr_is_cmd = 1'b1;
      usr_valid = 1'b1;
      step();
      usr_data = 8'h7E;
      usr_is_cmd = 1'b0;
      wait_log(base + 2, 200, "b2b_second");
      usr_valid = 1'b0;
      if (log_data.size() >= base + 2) begin
         checks++;
         if (log_data[base] !== 8'h81 || log_cmd[base] !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got %h/%b expected 81/1", log_data[base], log_cmd[base]);
         end
         checks++;
         if (log_data[base+1] !== 8'h7E || log_cmd[base+1] !== 1'b0) begin
            errors++; $display("FAIL b2b_second_byte: got %h/%b expected 7e/0", log_data[base+1], log_cmd[base+1]);
         end
         checks++;
         if (log_cyc[base+1] - log_cyc[base] != 25) begin
            errors++; $display("FAIL b2b_gap: got %0d expected 25", log_cyc[base+1] - log_cyc[base]);
         end
      end
      n = 0;
      while (usr_ready !== 1'b1 && n < 200) begin
         n++;
         step();
      end
   endtask

   task automatic test_valid_during_init();
      int u;
      rst = 1'b1;
      usr_data = 8'hC3;
      usr_is_cmd = 1'b0;
      usr_valid = 1'b1;
      repeat (3) step();
      clear_log();
      rst = 1'b0;
      u = 25 + NCLR;
      wait_log(u + 1, 3000, "early_valid_accept");
      usr_valid = 1'b0;
      if (log_data.size() >= u + 1) begin
         for (int i = 0; i < 25; i++) begin
            checks++;
            if (log_data[i] !== rom[i]) begin
               errors++; $display("FAIL early_valid_rom_%0d: got %h expected %h", i, log_data[i], rom[i]);
            end
         end
         checks++;
         if (log_data[u] !== 8'hC3 || log_cmd[u] !== 1'b0) begin
            errors++; $display("FAIL early_valid_byte: got %h/%b expected c3/0", log_data[u], log_cmd[u]);
         end
         checks++;
         if (log_cyc[u] - log_cyc[u-1] != 25) begin
            errors++; $display("FAIL early_valid_gap: got %0d expected 25", log_cyc[u] - log_cyc[u-1]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int c0;
      rst = 1'b1;
      repeat (3) step();
      clear_log();
      rst = 1'b0;
      wait_log(5, 500, "midrst_fifth");
      checks++; if (i2c_data !== 8'h3F) begin errors++; $display("FAIL midrst_fifth_byte: got %h expected 3f", i2c_data); end
      rst = 1'b1;
      step();
      checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL midrst_start: got %b expected 0", i2c_start); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL midrst_init_done: got %b expected 0", init_done); end
      checks++; if (i2c_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", i2c_data); end
      step();
      clear_log();
      c0 = cyc;
      rst = 1'b0;
      wait_log(1, 100, "midrst_restart");
      if (log_data.size() >= 1) begin
         checks++;
         if (log_cyc[0] - c0 != 10) begin errors++; $display("FAIL midrst_latency: got %0d expected 10", log_cyc[0] - c0); end
         checks++;
         if (log_data[0] !== 8'hAE) begin errors++; $display("FAIL midrst_restart_byte: got %h expected ae", log_data[0]); end
      end
   endtask

   task automatic test_timeout();
      int n, rdy_hi, st_hi;
      rst = 1'b1;
      busy_en = 1'b0;
      repeat (3) step();
      clear_log();
      rst = 1'b0;
      wait_log(1, 100, "timeout_first_start");
      n = 0;
      while (i2c_start === 1'b1 && n < 200) begin
         n++;
         step();
      end
      checks++; if (n != 50) begin errors++; $display("FAIL timeout_start_cycles: got %0d expected 50", n); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", err); end
      checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL timeout_start_low: got %b expected 0", i2c_start); end
      usr_valid = 1'b1;
      busy_en = 1'b1;
      rdy_hi = 0;
      st_hi = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (usr_ready !== 1'b0) rdy_hi++;
         if (i2c_start !== 1'b0) st_hi++;
      end
      usr_valid = 1'b0;
      checks++; if (rdy_hi != 0) begin errors++; $display("FAIL error_usr_ready: got %0d high cycles expected 0", rdy_hi); end
      checks++; if (st_hi != 0) begin errors++; $display("FAIL error_start: got %0d high cycles expected 0", st_hi); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b expected 1", err); end
   endtask

   task automatic test_protocol();
      checks++;
      if (viol != 0) begin errors++; $display("FAIL start_while_busy: got %0d events expected 0", viol); end
   endtask

   initial begin
      test_reset();
      test_init();
      test_user_byte(8'h5A, 1'b0);
      test_user_byte(8'hA5, 1'b1);
      test_back_to_back();
      test_valid_during_init();
      test_reset_mid();
      test_timeout();
      test_protocol();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
